// File: rtl/imul_iter_param.sv
// rtl/imul_iter_param.sv - iterative early-terminating shift-add multiplier with val/rdy streams
// Define IMUL_SIGNED_EN for two's-complement operands; unsigned when undefined.
module imul_iter_param #(
  parameter int NBITS = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2*NBITS-1:0] istream_msg,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] ostream_msg
);

  localparam int PW = 2 * NBITS;
  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     a_reg, acc;
  logic [NBITS-1:0]  b_reg;
  logic [CW-1:0]     cnt;
  logic [NBITS-1:0]  a_in, b_in, a_ld, b_ld;
  logic              last_iter;

  assign a_in = istream_msg[PW-1:NBITS];
  assign b_in = istream_msg[NBITS-1:0];

  // Stop once no multiplier bits remain after this iteration's shift.
  assign last_iter = ((b_reg >> 1) == '0) || (cnt == CW'(NBITS - 1));

`ifdef IMUL_SIGNED_EN
  logic neg;

  // Unsigned negation maps the most negative value onto its own magnitude.
  assign a_ld = a_in[NBITS-1] ? -a_in : a_in;
  assign b_ld = b_in[NBITS-1] ? -b_in : b_in;
  assign ostream_msg = neg ? -acc : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg <= 1'b0;
    end else if (state == IDLE && istream_val) begin
      neg <= a_in[NBITS-1] ^ b_in[NBITS-1];
    end
  end
`else
  assign a_ld = a_in;
  assign b_ld = b_in;
  assign ostream_msg = acc;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (istream_val) begin
            a_reg <= {{NBITS{1'b0}}, a_ld};
            b_reg <= b_ld;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          if (b_reg[0]) begin
            acc <= acc + a_reg;
          end
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
